sequence_player_module: RTL
===========================

Name: sequence_player_module

Overview:
- Consumer end of the controls interface.
- Captures each colour value (1-4) the random generator produces and appends it to the round sequence. On request it replays the sequence to the LED driver with timed on/off phases.
- It then checks the player's guesses against the stored sequence, one per colour.
- It sits between the generator and the game FSM / LED / button blocks.

Parameters:
- MAX_LEN, 32, maximum stored sequence length (entries).
- ON_CYCLES, 25_000_000, clock cycles each colour is shown.
- OFF_CYCLES, 12_500_000, clock cycles of blank gap after each colour.

Ports:
- i_clk  input  1  system clock; single clock domain, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- controls  interface (consumer)  value 3 / ready 1  colour value (1-4) plus ready strobe from the generator.
- i_enable  input  1  module enable; low aborts to IDLE.
- i_clear  input  1  empties the sequence (length := 0).
- i_play  input  1  starts playback of the stored sequence.
- i_guess_valid  input  1  player guess strobe, one cycle.
- i_guess  input  3  guessed colour, 1-4.
- o_color  output  3  colour being shown; 0 when none.
- o_color_valid  output  1  high during the ON phase.
- o_show_done  output  1  one-cycle pulse when playback finishes.
- o_round_ok  output  1  one-cycle pulse when the full sequence is matched.
- o_round_fail  output  1  one-cycle pulse on the first wrong guess.
- o_drop  output  1  one-cycle pulse when an incoming value is discarded.
- o_length  output  $clog2(MAX_LEN+1)  current stored length.
- o_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0):
  - State IDLE; length, index and timer are 0.
  - All outputs are 0.
  - Memory contents are don't-care.
- Capture: a new value is detected on a rising edge of controls.ready (ready=1 this cycle, 0 the previous cycle). Level-held ready counts once.
  - Accepted only in IDLE with i_enable=1, length<MAX_LEN and controls.value in 1..4.
  - On acceptance, mem[length] := value and o_length increments the cycle after the edge.
  - Otherwise (full, busy, value 0 or 5-7, i_enable=0) the value is discarded and o_drop pulses the cycle after.
- Priorities in IDLE within one cycle:
  - i_clear has highest priority: it suppresses both the append and the play.
  - Append with i_play in the same cycle: the element is appended and playback uses the new length.
- State IDLE:
  - i_play with length>0: go to SHOW_ON with index=0.
  - i_play with length=0: o_show_done pulses next cycle and the state stays IDLE.
- State SHOW_ON:
  - o_color=mem[index] and o_color_valid=1 for exactly ON_CYCLES cycles.
  - The first valid cycle is the cycle after i_play is sampled.
  - Then go to SHOW_OFF.
- State SHOW_OFF:
  - o_color=0 and o_color_valid=0 for exactly OFF_CYCLES cycles.
  - If index=length-1: go to CHECK with index:=0 and pulse o_show_done on entry to CHECK.
  - Else: index++ and return to SHOW_ON.
- State CHECK, on i_guess_valid:
  - i_guess==mem[index] and index==length-1: pulse o_round_ok next cycle and go to IDLE.
  - i_guess==mem[index] otherwise: index++ and stay in CHECK.
  - Mismatch (including guess 0 or 5-7): pulse o_round_fail next cycle and go to IDLE.
  - Guesses are ignored outside CHECK.
- Sequence retention: the sequence and length are kept after a round completes or fails; only i_clear or reset empties them.
- Timer: counter width $clog2(max(ON_CYCLES,OFF_CYCLES)). It reloads on each phase entry; no phase is shortened or lengthened by other inputs.
- i_enable=0 in any state:
  - Synchronous abort to IDLE next cycle.
  - o_color and o_color_valid go to 0; no done/ok/fail pulse.
  - Length is kept.
- i_clear during SHOW/CHECK is ignored; it is honoured in IDLE only.
- Reset mid-operation clears everything immediately, regardless of the clock.
- All outputs are registered; pulses last exactly one cycle.

Test Plan:
1. Reset, then ready edges carrying 3, 1, 4 -> o_length steps 1, 2, 3 one cycle after each edge; o_drop stays 0.
2. ON_CYCLES=4, OFF_CYCLES=2, sequence 3,1,4, i_play at cycle 0 ->
   - o_color_valid high in cycles 1-4 (o_color=3), 7-10 (o_color=1) and 13-16 (o_color=4), low otherwise.
   - o_show_done pulses in cycle 19.
3. After scenario 2, guesses 3, 1, 4 -> o_round_ok single pulse after the third guess; o_busy=0 afterwards. Repeat with guesses 3, 2 -> o_round_fail after the second guess.
4. MAX_LEN=4: six ready edges with value 2 -> o_length saturates at 4; o_drop pulses twice. A ready held high for 5 cycles counts as one value. Value 0 is dropped.
5. Same cycle: i_clear+i_play+ready edge in IDLE -> length=0, no playback. Then i_play with length 0 -> o_show_done the next cycle.
6. Reset mid-operation: i_rst_n low in cycle 8 of playback -> all outputs 0 asynchronously and o_length=0. Separately, i_enable low mid-playback -> IDLE next cycle with length retained.

Source files
------------

// File: rtl/sequence_player_module_if.sv
// Generator-to-player link: a colour value qualified by a ready strobe.
interface sequence_player_module_if;
    logic [2:0] value;
    logic       ready;

    modport master (output value, output ready);
    modport slave  (input value, input ready);
endinterface

// File: rtl/sequence_player_module.sv
// Stores generated colours, replays them with timed ON/OFF phases, then
// checks the player's guesses against the stored sequence.
module sequence_player_module #(
    parameter int MAX_LEN    = 32,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    sequence_player_module_if.slave  controls,
    input  logic                     i_enable,
    input  logic                     i_clear,
    input  logic                     i_play,
    input  logic                     i_guess_valid,
    input  logic [2:0]               i_guess,
    output logic [2:0]               o_color,
    output logic                     o_color_valid,
    output logic                     o_show_done,
    output logic                     o_round_ok,
    output logic                     o_round_fail,
    output logic                     o_drop,
    output logic [LEN_W-1:0]         o_length,
    output logic                     o_busy
);

    localparam int MAX_PH = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TMR_W-1:0] TMR_ON  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_OFF = TMR_W'(OFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, SHOW_ON, SHOW_OFF, CHECK} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [LEN_W-1:0]   index_q, index_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               ready_prev_q;
    logic [2:0]         color_q, color_d;
    logic               color_valid_q, color_valid_d;
    logic               show_done_q, show_done_d;
    logic               round_ok_q, round_ok_d;
    logic               round_fail_q, round_fail_d;
    logic               drop_q, drop_d;
    logic               busy_q, busy_d;

    logic [2:0]         mem_q [MAX_LEN];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [2:0]         mem_wdata;

    logic               rise, value_ok, append, last;
    logic [LEN_W-1:0]   len_eff, idx_inc;
    logic [2:0]         cur_mem, next_mem, first_color;

    always_comb begin
        rise     = controls.ready & ~ready_prev_q;
        value_ok = (controls.value != 3'd0) && (controls.value <= 3'd4);
        append   = rise && (state_q == IDLE) && i_enable && !i_clear &&
                   (length_q < LEN_MAX) && value_ok;
        len_eff  = append ? length_q + LEN_ONE : length_q;
        last     = (index_q == length_q - LEN_ONE);
        idx_inc  = index_q + LEN_ONE;
        cur_mem  = mem_q[index_q[IDX_W-1:0]];
        next_mem = mem_q[idx_inc[IDX_W-1:0]];
        // The value appended in the play cycle is not in memory yet.
        first_color = (length_q == '0) ? controls.value : mem_q[0];
    end

    always_comb begin
        state_d       = state_q;
        length_d      = length_q;
        index_d       = index_q;
        timer_d       = timer_q;
        color_d       = 3'd0;
        color_valid_d = 1'b0;
        show_done_d   = 1'b0;
        round_ok_d    = 1'b0;
        round_fail_d  = 1'b0;
        drop_d        = rise & ~append;
        mem_we        = append;
        mem_waddr     = length_q[IDX_W-1:0];
        mem_wdata     = controls.value;

        if (!i_enable) begin
            state_d = IDLE;
            index_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_clear) begin
                        length_d = '0;
                    end else begin
                        length_d = len_eff;
                        if (i_play) begin
                            if (len_eff == '0) begin
                                show_done_d = 1'b1;
                            end else begin
                                state_d       = SHOW_ON;
                                index_d       = '0;
                                timer_d       = TMR_ON;
                                color_d       = first_color;
                                color_valid_d = 1'b1;
                            end
                        end
                    end
                end
                SHOW_ON: begin
                    if (timer_q == '0) begin
                        state_d = SHOW_OFF;
                        timer_d = TMR_OFF;
                    end else begin
                        timer_d       = timer_q - TMR_W'(1);
                        color_d       = color_q;
                        color_valid_d = 1'b1;
                    end
                end
                SHOW_OFF: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else if (last) begin
                        state_d     = CHECK;
                        index_d     = '0;
                        show_done_d = 1'b1;
                    end else begin
                        state_d       = SHOW_ON;
                        index_d       = idx_inc;
                        timer_d       = TMR_ON;
                        color_d       = next_mem;
                        color_valid_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (i_guess_valid) begin
                        if (i_guess != cur_mem) begin
                            round_fail_d = 1'b1;
                            state_d      = IDLE;
                            index_d      = '0;
                        end else if (last) begin
                            round_ok_d = 1'b1;
                            state_d    = IDLE;
                            index_d    = '0;
                        end else begin
                            index_d = idx_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            length_q      <= '0;
            index_q       <= '0;
            timer_q       <= '0;
            ready_prev_q  <= 1'b0;
            color_q       <= 3'd0;
            color_valid_q <= 1'b0;
            show_done_q   <= 1'b0;
            round_ok_q    <= 1'b0;
            round_fail_q  <= 1'b0;
            drop_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            length_q      <= length_d;
            index_q       <= index_d;
            timer_q       <= timer_d;
            ready_prev_q  <= controls.ready;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            show_done_q   <= show_done_d;
            round_ok_q    <= round_ok_d;
            round_fail_q  <= round_fail_d;
            drop_q        <= drop_d;
            busy_q        <= busy_d;
        end
    end

    // Sequence storage carries no reset; only entries below length are read.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign o_color       = color_q;
    assign o_color_valid = color_valid_q;
    assign o_show_done   = show_done_q;
    assign o_round_ok    = round_ok_q;
    assign o_round_fail  = round_fail_q;
    assign o_drop        = drop_q;
    assign o_length      = length_q;
    assign o_busy        = busy_q;

endmodule
